// File: rtl/ha_pkg.sv
// ha_pkg: shared definitions for the bit-serial adder sequencer.
//   ST_IDLE / ST_RUN / ST_DONE : state encodings (2'd3 is unused and behaves as IDLE)
//   ha_state_e                 : FSM state type built on those encodings
//   clog2()                    : ceiling log2 used to size the bit-index counter
package ha_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DONE  = ST_DONE,
        S_SPARE = 2'd3
    } ha_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ha_bit_cell.sv
// ha_bit_cell: combinational half adder.
//   a, b : input bits
//   s    : a ^ b
//   c    : a & b
module ha_bit_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha_serial_add_seq.sv
// ha_serial_add_seq: bit-serial adder sequencer around one shared full-adder
// step (two half-adder cells plus an OR). Operands are accepted over a
// valid/ready handshake, summed LSB-first one bit per clock, and the result
// is held until the consumer takes it.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is high in IDLE)
//   a_in, b_in, cin      : operands and carry-in, captured on acceptance
//   abort                : drop any operation in flight, return to IDLE
//   out_valid / out_ready: result handshake (out_valid is high in DONE)
//   sum_out, cout_out    : registered sum (mod 2^WIDTH) and carry-out
//   busy                 : high whenever the block is not IDLE
//   dbg_state            : current FSM state encoding
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Ready and valid are decoded from the state register
// only, so neither depends combinationally on the partner's signal; once a
// producer raises valid it must hold its data until the transfer edge.
module ha_serial_add_seq
    import ha_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    ha_state_e        state;
    ha_state_e        state_next;

    // Operands are kept as right-shift registers so the active bit is always
    // at position 0; this avoids a variable-index read mux on the operands.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] sum_next;

    logic             ha0_s;
    logic             ha0_c;
    logic             fa_s;
    logic             ha1_c;
    logic             fa_c;
    logic             is_idle;
    logic             last_bit;
    logic             accept;

    // Full-adder step: first cell adds the operand bits, second adds carry.
    ha_bit_cell u_ha0 (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    ha_bit_cell u_ha1 (
        .a (ha0_s),
        .b (carry),
        .s (fa_s),
        .c (ha1_c)
    );

    assign fa_c = ha0_c | ha1_c;

    // The spare encoding behaves exactly like IDLE.
    assign is_idle   = (state == S_IDLE) || (state == S_SPARE);
    assign in_ready  = is_idle;
    assign out_valid = (state == S_DONE);
    assign busy      = !is_idle;
    assign dbg_state = state;

    assign last_bit  = (idx == CNT_W'(WIDTH - 1));
    assign accept    = is_idle && in_valid;

    // Write the current sum bit into its slot, leaving the rest untouched.
    always_comb begin
        sum_next = sum_out;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == CNT_W'(i)) begin
                sum_next[i] = fa_s;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = in_valid ? S_RUN : S_IDLE;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else if (abort) begin
            // Partial sum/carry-out stay visible; only the walk state clears.
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            carry    <= cin;
            idx      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else if (state == S_RUN) begin
            sum_out <= sum_next;
            carry   <= fa_c;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            if (last_bit) begin
                cout_out <= fa_c;
                idx      <= '0;
            end else begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

endmodule
